// File: rtl/simon_pkg.sv
// Shared definitions for the Simon player-input path and the game core.
package simon_pkg;

  localparam int unsigned NUM_BUTTONS = 4;
  localparam int unsigned BTN_IDX_W   = 2;

  typedef logic [NUM_BUTTONS-1:0] btn_vec_t;
  typedef logic [BTN_IDX_W-1:0]   btn_idx_t;

  typedef enum logic {
    IDLE,
    HELD
  } state_t;

  // True when exactly one button bit is set.
  function automatic logic one_hot(input btn_vec_t v);
    return (v != '0) && ((v & (v - btn_vec_t'(1))) == '0);
  endfunction

  // Index of the set bit; only meaningful for a one-hot vector.
  function automatic btn_idx_t btn_index(input btn_vec_t v);
    btn_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      if (v[i]) idx = btn_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/simon_debounce.sv
// One button: two-flop synchroniser followed by a stability counter that
// only moves the debounced level after DEBOUNCE_CYCLES identical samples.
module simon_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has been stable long enough; any
  // return to the current level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= s2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/simon_button_input.sv
// Player-input front end for the Simon core: debounces four buttons,
// reports single-button press edges as a strobe plus button number, and
// flags presses involving more than one button.
module simon_button_input
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  input  logic                   enable,
  output logic [BTN_IDX_W-1:0]   player_num,
  output logic                   player_pressed,
  output logic                   multi_err,
  output logic [NUM_BUTTONS-1:0] btn_level
);

  state_t   state;
  btn_vec_t lvl_q;
  btn_vec_t rise;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    simon_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_raw[g]),
      .level (btn_level[g])
    );
  end

  // Buttons whose debounced level went high this cycle.
  always_comb begin
    rise = btn_level & ~lvl_q;
  end

  // Press-episode FSM: one strobe (press or multi error) per episode, then
  // wait in HELD until every button is released. Rises seen while HELD are
  // dropped, since lvl_q catches up the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      lvl_q          <= '0;
      player_num     <= '0;
      player_pressed <= 1'b0;
      multi_err      <= 1'b0;
    end else begin
      lvl_q          <= btn_level;
      player_pressed <= 1'b0;
      multi_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (rise != '0) begin
            if (one_hot(btn_level)) begin
              if (enable) begin
                player_pressed <= 1'b1;
                player_num     <= btn_index(btn_level);
              end
            end else begin
              multi_err <= 1'b1;
            end
            state <= HELD;
          end
        end
        HELD: begin
          if (btn_level == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/simon_button_input.md
Name: simon_button_input

Overview:
- Upstream stage of the Simon game core.
- Turns four raw, bouncing, asynchronous push-buttons into the core's player-input pair:
  - a 2-bit button number (core input playerNum);
  - a one-cycle press strobe (core input playerPressed).
- Synchronises, debounces and edge-detects each button. Rejects multi-button presses. Suppresses input while the core is not accepting it (Simon's turn or game over).

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronised level must stay stable before it is accepted (1 ms at 50 MHz); legal range 2..65535.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- btn_raw  input  4  raw buttons, active-high, asynchronous to clk; bit i = button i.
- enable  input  1  high when the core accepts player input; top level drives it as ~simonTurn & ~gameOver.
- player_num  output  2  index of the last accepted button; feeds the core's playerNum.
- player_pressed  output  1  one-cycle strobe per accepted press; feeds the core's playerPressed.
- multi_err  output  1  one-cycle strobe when a press is rejected because more than one button is down.
- btn_level  output  4  debounced button levels, for LED echo.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all flops to 0. player_num=0, player_pressed=0, multi_err=0, btn_level=0, FSM=IDLE, all counters=0.
- Synchroniser: per bit, a 2-flop chain btn_raw -> s1 -> s2. No logic between the two flops.
- Debounce, per bit i (independent counters):
  - if s2[i]==btn_level[i]: cnt[i]<=0;
  - else if cnt[i]==DEBOUNCE_CYCLES-1: btn_level[i]<=s2[i] and cnt[i]<=0;
  - else cnt[i]<=cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES clears the counter and never reaches btn_level.
- Edge detect:
  - lvl_q registers btn_level.
  - rise = btn_level & ~lvl_q, evaluated combinationally in the FSM.
- FSM states: IDLE, HELD.
  - IDLE, rise==0: stay.
  - IDLE, rise!=0 and btn_level has exactly one bit set:
    - if enable=1: player_pressed<=1, player_num<=index of that bit;
    - if enable=0: no strobe, press swallowed;
    - go HELD in both cases.
  - IDLE, rise!=0 and more than one bit of btn_level set (simultaneous press, or a second button while one is held):
    - multi_err<=1 (regardless of enable);
    - no player_pressed;
    - go HELD.
  - HELD: no strobes. Go IDLE when btn_level==0.
    - New rises seen in HELD are ignored and never deferred.
- Latency: raw rising edge stable from sample edge E:
  - s2 high at E+2;
  - btn_level high at E+2+DEBOUNCE_CYCLES;
  - player_pressed high for exactly the following cycle, E+3+DEBOUNCE_CYCLES.
- Strobe rules:
  - player_pressed and multi_err are never high together.
  - Each is high for exactly one cycle.
  - At most one strobe per press/release episode.
- player_num holds its value between strobes and is valid whenever player_pressed=1.
- enable is sampled only in the IDLE cycle where a rise occurs.
  - A button held while enable rises does not generate a press; there is no edge.
- Release is not reported; only press edges are reported.
- Reset mid-operation:
  - returns to the reset state immediately;
  - a button held through reset release debounces as a new rise and is reported as a press if enable=1.

Decomposition:
- Shared package simon_pkg:
  - NUM_BUTTONS=4;
  - BTN_IDX_W=2;
  - state enum {IDLE, HELD}.
- The core reuses BTN_IDX_W for its own button-number width.
- One sub-module is natural: simon_debounce (1-bit 2-flop synchroniser + counter), instantiated 4 times.
- The FSM and index encoder stay in the top module.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4.
- Single press: btn_raw=4'b0100 held 20 cycles, enable=1 -> one player_pressed pulse 7 cycles after the first sampling edge, player_num=2, btn_level=4'b0100; on release, no further strobe and the FSM returns to IDLE.
- Bounce: btn_raw[1] toggles every 2 cycles for 12 cycles, then stays 1 -> btn_level[1] rises only after the final 4 stable cycles; exactly one strobe, player_num=1.
- Disabled: enable=0, press button 3 -> no player_pressed; raise enable while the button is held -> still no strobe; release, press again -> strobe, player_num=3.
- Multi-press: buttons 0 and 2 rise in the same cycle -> multi_err=1 for one cycle, player_pressed stays 0; hold button 0, then press button 1 -> no strobe of either kind until all are released.
- Reset mid-debounce: button 1 held, rst_n low for 1 cycle at counter=2 -> all outputs 0 immediately; after release of rst_n the button re-debounces and one strobe occurs with player_num=1.
- Back-to-back: presses 0,1,2,3 each 8 cycles with 8-cycle gaps -> four strobes, player_num sequence 0,1,2,3, each strobe one cycle wide.
